fc_sequencer: RTL and testbench

//   Control FSM for the fully-connected classifier layer. Walks N_OUT neurons x N_IN inputs,

---
 rtl/fc_sequencer.sv | 117 +++++++++++
 tb/tb_fc_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fc_sequencer.sv
// fc_sequencer: walks N_OUT neurons x N_IN inputs for the FC datapath and tracks the argmax.
// Addresses are registered so they line up with the one-cycle ROM latency seen by mac_en.
module fc_sequencer #(
   parameter int N_IN  = 12,
   parameter int N_OUT = 10,
   parameter int IN_AW = 4,
   parameter int W_AW  = 7,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ACC_W-1:0] mac_acc,
   output logic             busy,
   output logic [IN_AW-1:0] feat_addr,
   output logic [W_AW-1:0]  w_addr,
   output logic [3:0]       neuron_idx,
   output logic             mac_clr,
   output logic             mac_en,
   output logic [3:0]       class_out,
   output logic             done
);
   typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, CMP, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] j_q, j_d;
   logic [IN_AW-1:0] feat_addr_q, feat_addr_d;
   logic [W_AW-1:0] w_addr_q, w_addr_d;
   logic mac_en_q, mac_en_d;
   logic signed [ACC_W-1:0] best_q, best_d;
   logic [3:0] best_idx_q, best_idx_d;
   logic [3:0] class_q, class_d;
   logic last_i, last_j, win;
   localparam logic signed [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};
   always_comb begin
      last_i = feat_addr_q == IN_AW'(N_IN - 1);
      last_j = j_q == 4'(N_OUT - 1);
      win = $signed(mac_acc) > best_q;
      state_d = state_q;
      j_d = j_q;
      feat_addr_d = feat_addr_q;
      w_addr_d = w_addr_q;
      best_d = best_q;
      best_idx_d = best_idx_q;
      class_d = class_q;
      mac_en_d = state_q == MAC;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLR;
               j_d = 4'd0;
            end
         end
         CLR: begin
            state_d = MAC;
            feat_addr_d = '0;
            // weight addresses run contiguously across neurons, restarting only at neuron 0
            w_addr_d = (j_q == 4'd0) ? '0 : w_addr_q + W_AW'(1);
            if (j_q == 4'd0) begin
               best_d = MOST_NEG;
               best_idx_d = 4'd0;
            end
         end
         MAC: begin
            if (last_i) state_d = DRAIN;
            else begin
               feat_addr_d = feat_addr_q + IN_AW'(1);
               w_addr_d = w_addr_q + W_AW'(1);
            end
         end
         DRAIN: state_d = CMP;
         CMP: begin
            if (win) begin
               best_d = $signed(mac_acc);
               best_idx_d = j_q;
            end
            if (last_j) begin
               state_d = DONE;
               class_d = win ? j_q : best_idx_q;
            end else begin
               state_d = CLR;
               j_d = j_q + 4'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         j_q <= 4'd0;
         feat_addr_q <= '0;
         w_addr_q <= '0;
         mac_en_q <= 1'b0;
         best_q <= MOST_NEG;
         best_idx_q <= 4'd0;
         class_q <= 4'hF;
      end else begin
         state_q <= state_d;
         j_q <= j_d;
         feat_addr_q <= feat_addr_d;
         w_addr_q <= w_addr_d;
         mac_en_q <= mac_en_d;
         best_q <= best_d;
         best_idx_q <= best_idx_d;
         class_q <= class_d;
      end
   end
   assign busy = state_q != IDLE;
   assign mac_clr = state_q == CLR;
   assign done = state_q == DONE;
   assign mac_en = mac_en_q;
   assign feat_addr = feat_addr_q;
   assign w_addr = w_addr_q;
   assign neuron_idx = j_q;
   assign class_out = class_q;
endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: cycle-offset model of a run checked every cycle, plus literal class/latency checks.
module tb_fc_sequencer;
   localparam int N_IN = 12, N_OUT = 10, IN_AW = 4, W_AW = 7, ACC_W = 16;
   localparam int PER = N_IN + 3, RUN = N_OUT * PER;
   logic clk = 0, rst = 1, start = 0;
   logic [ACC_W-1:0] mac_acc = '0;
   logic busy, mac_clr, mac_en, done;
   logic [IN_AW-1:0] feat_addr;
   logic [W_AW-1:0] w_addr;
   logic [3:0] neuron_idx, class_out;
   fc_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_AW(IN_AW), .W_AW(W_AW), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .start(start), .mac_acc(mac_acc), .busy(busy),
      .feat_addr(feat_addr), .w_addr(w_addr), .neuron_idx(neuron_idx), .mac_clr(mac_clr),
      .mac_en(mac_en), .class_out(class_out), .done(done)
   );
   always #5 clk = ~clk;
   int total = 0, passed = 0, cyc = 0, phase = -1;
   int done_cnt = 0, clr_cnt = 0, en_cnt = 0;
   logic [3:0] exp_class = 4'hF;
   logic [ACC_W-1:0] tbl [N_OUT];
   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask
   function automatic logic [3:0] argmax();
      int b = 0;
      for (int j = 1; j < N_OUT; j++) if ($signed(tbl[j]) > $signed(tbl[b])) b = j;
      return 4'(b);
   endfunction
   // phase = cycles since the run's CLR of neuron 0, -1 when idle
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         phase = -1;
         exp_class = 4'hF;
      end else if (phase < 0) phase = start ? 0 : -1;
      else if (phase == RUN) phase = -1;
      else begin
         phase++;
         if (phase == RUN) exp_class = argmax();
      end
   end
   always @(negedge clk) begin
      int k, r;
      k = phase / PER;
      r = phase % PER;
      chk("busy", busy, phase >= 0);
      chk("done", done, phase == RUN);
      chk("mac_clr", mac_clr, phase >= 0 && phase < RUN && r == 0);
      chk("mac_en", mac_en, phase >= 0 && phase < RUN && r >= 2 && r <= N_IN + 1);
      chk("class_out", class_out, exp_class);
      if (phase >= 0 && phase < RUN) chk("neuron_idx", neuron_idx, k);
      if (phase >= 0 && phase < RUN && r >= 1 && r <= N_IN) begin
         chk("feat_addr", feat_addr, r - 1);
         chk("w_addr", w_addr, k * N_IN + r - 1);
      end
      mac_acc = (phase >= 0 && phase < RUN) ? tbl[k] : '0;
      if (done) done_cnt++;
      if (mac_clr) clr_cnt++;
      if (mac_en) en_cnt++;
   end
   task automatic wait_done(input string name, input int t0);
      for (int n = 0; n < 200 && !done; n++) @(negedge clk);
      chk({name, "_seen"}, done, 1);
      chk({name, "_lat"}, cyc - t0, RUN);
   endtask
   task automatic run(input string name, input logic [3:0] cls);
      int t0;
      start = 1;
      @(negedge clk);
      start = 0;
      t0 = cyc;
      wait_done(name, t0);
      chk({name, "_class"}, class_out, cls);
      @(negedge clk);
   endtask
   task automatic fill(input int base_step);
      for (int j = 0; j < N_OUT; j++) tbl[j] = ACC_W'(j * base_step);
   endtask
   initial begin
      int t0, t1, t2, d0;
      fill(16);
      repeat (2) @(negedge clk);
      chk("rst_class", class_out, 4'hF);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", mac_en, 0);
      chk("rst_clr", mac_clr, 0);
      rst = 0;
      @(negedge clk);
      tbl[7] = 16'h7FFF;
      clr_cnt = 0;
      en_cnt = 0;
      d0 = done_cnt;
      run("argmax7", 4'd7);
      chk("clr_count", clr_cnt, 10);
      chk("en_count", en_cnt, 120);
      chk("done_count", done_cnt - d0, 1);
      for (int j = 0; j < N_OUT; j++) tbl[j] = 16'h1000;
      run("tie", 4'd0);
      for (int j = 0; j < N_OUT; j++) tbl[j] = 16'hFF00;
      tbl[3] = 16'hFFFF;
      run("neg3", 4'd3);
      for (int j = 0; j < N_OUT; j++) tbl[j] = 16'h8000;
      run("minval", 4'd0);
      fill(16);
      start = 1;
      @(negedge clk);
      start = 0;
      for (int n = 0; n < 200 && phase != 5 * PER + 5; n++) @(negedge clk);
      chk("mid_reached", phase, 5 * PER + 5);
      d0 = done_cnt;
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("mid_busy", busy, 0);
      chk("mid_class", class_out, 4'hF);
      chk("mid_done", done, 0);
      repeat (100) @(negedge clk);
      chk("mid_nodone", done_cnt - d0, 0);
      run("fresh", 4'd9);
      t1 = -1;
      t2 = -1;
      d0 = done_cnt;
      start = 1;
      for (int n = 0; n < 400 && t2 < 0; n++) begin
         @(negedge clk);
         if (done && t1 < 0) t1 = cyc;
         else if (done) begin
            t2 = cyc;
            start = 0;
         end
      end
      repeat (20) @(negedge clk);
      chk("held_dones", done_cnt - d0, 2);
      chk("held_period", t2 - t1, 152);
      start = 1;
      @(negedge clk);
      start = 0;
      t0 = cyc;
      repeat (40) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done("busy_pulse", t0);
      chk("busy_pulse_class", class_out, 4'd9);
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
